legv8_mul_div: RTL

LEGV8_MUL_DIV -- requirements
Module: legv8_mul_div

---
 rtl/legv8_pkg.sv | 20 ++
 rtl/legv8_mul_div.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multiply/divide unit: datapath width,
// operation encodings and FSM state encoding.
package legv8_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/legv8_mul_div.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit sharing one
// double-width shift register; fixed 65-edge latency from start to done.
module legv8_mul_div
  import legv8_pkg::*;
#(
  parameter int unsigned XLEN = legv8_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      wr_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wr_out,
  output logic            div_by_zero
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0]   opb, opb_nx;
  op_e               op_q, op_nx;
  logic [4:0]        tag, tag_nx;
  logic              neg, neg_nx;
  logic              dbz_q, dbz_nx;
  logic              busy_nx, done_nx, div_by_zero_nx;
  logic [XLEN-1:0]   result_nx;
  logic [4:0]        wr_out_nx;

  op_e               op_in;
  logic              in_div, q_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_shift;
  logic [XLEN-1:0]   rem_diff, quo, final_res;
  logic              rem_ge;
  logic [2*XLEN-1:0] mul_step, div_step;

  // Operand conditioning at accept: SDIV works on magnitudes
  always_comb begin
    op_in  = op_e'(op);
    in_div = (op_in == OP_UDIV) || (op_in == OP_SDIV);
    q_div  = (op_q == OP_UDIV) || (op_q == OP_SDIV);
    a_mag  = (op_in == OP_SDIV && a[XLEN-1]) ? -a : a;
    b_mag  = (op_in == OP_SDIV && b[XLEN-1]) ? -b : b;
  end

  // One iteration: shift-add multiply step (acc = {hi, multiplier})
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    mul_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
  end

  // One iteration: restoring divide step (acc = {remainder, quotient})
  always_comb begin
    rem_shift = acc[2*XLEN-1:XLEN-1];
    rem_ge    = rem_shift >= {1'b0, opb};
    rem_diff  = rem_shift[XLEN-1:0] - opb;
    div_step  = rem_ge ? {rem_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  end

  always_comb begin
    quo       = acc[XLEN-1:0];
    final_res = quo;
    case (op_q)
      OP_MUL:   final_res = quo;
      OP_UMULH: final_res = acc[2*XLEN-1:XLEN];
      OP_UDIV:  final_res = dbz_q ? '0 : quo;
      OP_SDIV:  final_res = dbz_q ? '0 : (neg ? -quo : quo);
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    acc_nx         = acc;
    opb_nx         = opb;
    op_nx          = op_q;
    tag_nx         = tag;
    neg_nx         = neg;
    dbz_nx         = dbz_q;
    done_nx        = 1'b0;
    result_nx      = result;
    wr_out_nx      = wr_out;
    div_by_zero_nx = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx       = RUN;
          cnt_nx         = '0;
          acc_nx         = {XLEN'(0), a_mag};
          opb_nx         = b_mag;
          op_nx          = op_in;
          tag_nx         = wr_in;
          neg_nx         = a[XLEN-1] ^ b[XLEN-1];
          dbz_nx         = in_div && (b == '0);
          div_by_zero_nx = 1'b0;
        end
      end
      RUN: begin
        if (cnt != CW'(XLEN)) begin
          cnt_nx = cnt + CW'(1);
          acc_nx = q_div ? div_step : mul_step;
        end else begin
          state_nx       = DONE;
          done_nx        = 1'b1;
          result_nx      = final_res;
          wr_out_nx      = tag;
          div_by_zero_nx = dbz_q;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      op_q        <= OP_MUL;
      tag         <= '0;
      neg         <= 1'b0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      wr_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      acc         <= acc_nx;
      opb         <= opb_nx;
      op_q        <= op_nx;
      tag         <= tag_nx;
      neg         <= neg_nx;
      dbz_q       <= dbz_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      result      <= result_nx;
      wr_out      <= wr_out_nx;
      div_by_zero <= div_by_zero_nx;
    end
  end

endmodule
